// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-path types: instruction/address widths, the NOP encoding and the
// {pc, instr} entry carried through the prefetch queue.
package rv_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch queue: DEPTH registered entries, head visible combinationally,
// synchronous push/pop/flush; an empty queue keeps showing the last head.
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic         valid_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  last_q;
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  assign valid_o = (count_q != '0);
  assign count_o = count_q;
  assign do_pop  = pop_i && valid_o;
  assign head_o  = valid_o ? mem_q[rd_q] : last_q;

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= entry_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      last_q  <= '{pc: '0, instr: INSTR_NOP};
    end else begin
      if (valid_o) last_q <= mem_q[rd_q];
      if (flush_i) begin
        rd_q    <= wr_q;
        count_q <= '0;
      end else begin
        if (push_i) wr_q <= wr_q + 1'b1;
        if (do_pop) rd_q <= rd_q + 1'b1;
        count_q <= count_q + CW'(push_i) - CW'(do_pop);
      end
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !flush_i && !do_pop && count_q == CW'(DEPTH)));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues word reads under a credit limit, queues
// returned words with their PCs, and flushes/drops stale reads on redirect.
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d, drop_q, drop_d;
  logic [CW-1:0]   fifo_count;
  logic            en_q;
  logic [CW:0]     credit_used;
  logic            issue, accept;
  fetch_entry_t    head;

  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign imem_req    = en_q && (credit_used < CREDITS) && !redirect;
  assign imem_addr   = fetch_pc_q;
  assign issue       = imem_req && imem_gnt;
  assign accept      = imem_rvalid && (drop_q == '0) && !redirect;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q + CW'(issue) - CW'(imem_rvalid);
    drop_d     = drop_q;
    if (redirect) begin
      fetch_pc_d = align_word(redirect_pc);
      resp_pc_d  = align_word(redirect_pc);
      // inflight already includes words still pending in drop_q, so every
      // outstanding read after this edge is stale: replace, don't add.
      drop_d     = inflight_q - CW'(imem_rvalid);
    end else begin
      if (issue)  fetch_pc_d = fetch_pc_q + 32'd4;
      if (accept) resp_pc_d  = resp_pc_q + 32'd4;
      if (imem_rvalid && drop_q != '0) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      en_q       <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      en_q       <= 1'b1;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (accept),
    .entry_i ('{pc: resp_pc_q, instr: imem_rdata}),
    .pop_i   (instr_ready),
    .flush_i (redirect),
    .head_o  (head),
    .valid_o (instr_valid),
    .count_o (fifo_count)
  );

  assign instr    = head.instr;
  assign instr_pc = head.pc;

  assert property (@(posedge clk) disable iff (!rst_n) inflight_q <= CW'(DEPTH));
  assert property (@(posedge clk) disable iff (!rst_n) imem_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-configurable memory model
// and a scoreboard of expected {pc, instr} deliveries.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit drop; } pend_t;
  typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;

  int unsigned  n_tests = 0, n_fail = 0;
  int unsigned  n_issue = 0, n_disc = 0;
  int unsigned  cyc = 0;
  int unsigned  lat = 1;
  logic [31:0]  exp_fetch = '0;
  pend_t        pending[$];
  mreq_t        mem_q[$];
  logic [63:0]  exp_q[$];
  logic [31:0]  pop_log[$];

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  // memory: returns issued reads in order, no earlier than lat cycles after grant
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst_n) begin
      mem_q.delete();
      imem_rvalid = 1'b0;
    end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = tag(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
    end
  end

  // scoreboard: book-keeps what happens at the upcoming rising edge
  always @(negedge clk) begin
    pend_t p;
    logic [63:0] e;
    if (!rst_n) begin
      pending.delete();
      exp_q.delete();
      exp_fetch = 32'h0;
    end else begin
      if (instr_valid && instr_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_pop_pc", instr_pc, 32'hXXXX_XXXX);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", instr_pc, e[63:32]);
          chk("sb_instr", instr, e[31:0]);
        end
        pop_log.push_back(instr_pc);
      end
      if (imem_rvalid) begin
        if (pending.size() == 0) begin
          chk("sb_unexpected_rvalid", 32'(imem_rvalid), 32'd0);
        end else begin
          p = pending.pop_front();
          if (p.drop || redirect) n_disc++;
          else exp_q.push_back({p.addr, tag(p.addr)});
        end
      end
      if (imem_req && imem_gnt) begin
        chk("sb_fetch_addr", imem_addr, exp_fetch);
        pending.push_back('{addr: imem_addr, drop: 1'b0});
        mem_q.push_back('{addr: imem_addr, due: cyc + lat});
        exp_fetch = imem_addr + 32'd4;
        n_issue++;
      end
      if (redirect) begin
        foreach (pending[i]) pending[i].drop = 1'b1;
        exp_q.delete();
        exp_fetch = redirect_pc & 32'hFFFF_FFFC;
      end
    end
  end

  initial begin
    int unsigned base, gaps, disc_base;
    bit found;
    logic [31:0] wrap_exp [4];
    wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000; wrap_exp[3] = 32'h0000_0004;

    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; instr_ready = 1'b0; lat = 1;
    step(); step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc", instr_pc, 32'h0);

    // first fetch latency
    step(); rst_n = 1'b1; imem_gnt = 1'b1;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (imem_req && imem_gnt) begin found = 1; break; end
    end
    chk("first_gnt_seen", 32'(found), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    sample(); chk("lat_valid_1", 32'(instr_valid), 32'd0);
    sample(); chk("lat_valid_2", 32'(instr_valid), 32'd1);
    chk("lat_pc", instr_pc, 32'h0);
    chk("lat_instr", instr, tag(32'h0));

    // streaming
    step(); instr_ready = 1'b1;
    repeat (8) step();
    gaps = 0;
    repeat (20) begin sample(); if (!instr_valid) gaps++; end
    chk("stream_gaps", gaps, 32'd0);

    // reset mid-stream
    step(); rst_n = 1'b0; #1;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_instr", instr, 32'h0000_0013);
    chk("mid_rst_pc", instr_pc, 32'h0);

    // backpressure
    instr_ready = 1'b0; lat = 1;
    step(); step(); rst_n = 1'b1; base = n_issue;
    repeat (12) step();
    chk("bp_issues", n_issue - base, 32'd4);
    sample();
    chk("bp_req", 32'(imem_req), 32'd0);
    chk("bp_addr", imem_addr, 32'h10);
    pop_log.delete();
    step(); instr_ready = 1'b1;
    repeat (10) step();
    chk("bp_npops", 32'(pop_log.size() >= 5), 32'd1);
    if (pop_log.size() >= 5)
      for (int i = 0; i < 5; i++) chk("bp_order", pop_log[i], 32'(i * 4));

    // redirect with three reads in flight
    step(); rst_n = 1'b0; instr_ready = 1'b0; lat = 3;
    step(); step(); rst_n = 1'b1; base = n_issue;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (imem_req && imem_gnt && n_issue == base + 3) begin found = 1; break; end
    end
    chk("rd_three_inflight", 32'(found), 32'd1);
    step(); redirect = 1'b1; redirect_pc = 32'h0000_0103; disc_base = n_disc;
    sample();
    chk("rd_rvalid_same_cycle", 32'(imem_rvalid), 32'd1);
    chk("rd_req_gated", 32'(imem_req), 32'd0);
    step(); redirect = 1'b0;
    sample();
    chk("rd_valid_after", 32'(instr_valid), 32'd0);
    chk("rd_next_addr", imem_addr, 32'h100);
    pop_log.delete(); instr_ready = 1'b1;
    repeat (15) step();
    chk("rd_dropped", n_disc - disc_base, 32'd3);
    chk("rd_npops", 32'(pop_log.size() >= 1), 32'd1);
    if (pop_log.size() >= 1) chk("rd_first_pc", pop_log[0], 32'h100);

    // redirect coincident with rvalid and pop, then again to 0x200
    lat = 1;
    repeat (10) step();
    redirect = 1'b1; redirect_pc = 32'h0000_0180;
    sample();
    chk("r5_rvalid", 32'(imem_rvalid), 32'd1);
    chk("r5_pop_req", 32'(instr_valid && instr_ready), 32'd1);
    step(); redirect = 1'b0;
    sample();
    chk("r5_empty", 32'(instr_valid), 32'd0);
    step(); redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step(); redirect = 1'b0; pop_log.delete();
    repeat (12) step();
    chk("r5_npops", 32'(pop_log.size() >= 2), 32'd1);
    if (pop_log.size() >= 2) begin
      chk("r5_first_pc", pop_log[0], 32'h200);
      chk("r5_second_pc", pop_log[1], 32'h204);
    end

    // address wrap
    step(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step(); redirect = 1'b0; pop_log.delete();
    repeat (10) step();
    chk("wrap_npops", 32'(pop_log.size() >= 4), 32'd1);
    if (pop_log.size() >= 4)
      for (int i = 0; i < 4; i++) chk("wrap_pc", pop_log[i], wrap_exp[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
